clint: RTL and testbench

Core-local interruptor for the small RISC-V core: holds a 64-bit `mtime` advanced by an internally divided RTC tick, a 64-bit `mtimecmp`, and the `msip` bit, and drives the machine timer and software interrupt lines. Sits on the data-memory bus behind the address decoder at `clint_base_addr`..`clint_top_addr`, next to the UART and BRAM.

---
 rtl/clint.sv | 131 +++++++++++++
 tb/tb_clint.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip registers, RTC tick divider,
// and the machine timer/software interrupt lines, on a one-cycle valid/ready bus.
module clint #(
    parameter logic [31:0] clint_base_addr = 32'h0200_0000,
    parameter int unsigned clk_divider_rtc = 761
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    localparam int unsigned DIV_W = (clk_divider_rtc > 0) ? $clog2(clk_divider_rtc + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(clk_divider_rtc);

    localparam logic [31:0] OFF_MSIP     = 32'h0000_0000;
    localparam logic [31:0] OFF_MTCMP_LO = 32'h0000_4000;
    localparam logic [31:0] OFF_MTCMP_HI = 32'h0000_4004;
    localparam logic [31:0] OFF_MTIME_LO = 32'h0000_BFF8;
    localparam logic [31:0] OFF_MTIME_HI = 32'h0000_BFFC;

    logic [DIV_W-1:0] div_cnt;
    logic             rtc;
    logic             rtc_d;
    logic             tick;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    logic [63:0] mtime_nxt;
    logic [63:0] mtimecmp_nxt;
    logic        msip_nxt;
    logic [31:0] rdata_nxt;

    logic [31:0] offset;
    logic        is_write;
    logic        is_read;

    // Byte-lane merge of write data into an existing word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    assign offset   = clint_addr - clint_base_addr;
    assign is_write = clint_valid && !clint_instr && (clint_wstrb != 4'b0000);
    assign is_read  = clint_valid && !is_write;
    assign tick     = rtc && !rtc_d;

    assign clint_mtime = mtime;

    // Free-running RTC divider; a tick is the rising edge of the rtc level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            rtc     <= 1'b0;
            rtc_d   <= 1'b0;
        end else begin
            rtc_d <= rtc;
            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
                rtc     <= ~rtc;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Next register values: bus writes override the tick on the written word.
    always_comb begin
        mtime_nxt    = tick ? (mtime + 64'd1) : mtime;
        mtimecmp_nxt = mtimecmp;
        msip_nxt     = clint_msip;
        rdata_nxt    = 32'h0;

        if (is_write) begin
            unique case (offset)
                OFF_MSIP:     if (clint_wstrb[0]) msip_nxt = clint_wdata[0];
                OFF_MTCMP_LO: mtimecmp_nxt[31:0]  = merge_bytes(mtimecmp[31:0],  clint_wdata, clint_wstrb);
                OFF_MTCMP_HI: mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], clint_wdata, clint_wstrb);
                OFF_MTIME_LO: mtime_nxt = {mtime[63:32], merge_bytes(mtime[31:0], clint_wdata, clint_wstrb)};
                OFF_MTIME_HI: mtime_nxt = {merge_bytes(mtime[63:32], clint_wdata, clint_wstrb), mtime[31:0]};
                default: ;
            endcase
        end

        if (is_read) begin
            unique case (offset)
                OFF_MSIP:     rdata_nxt = {31'h0, clint_msip};
                OFF_MTCMP_LO: rdata_nxt = mtimecmp[31:0];
                OFF_MTCMP_HI: rdata_nxt = mtimecmp[63:32];
                OFF_MTIME_LO: rdata_nxt = mtime[31:0];
                OFF_MTIME_HI: rdata_nxt = mtime[63:32];
                default:      rdata_nxt = 32'h0;
            endcase
        end
    end

    // Register file, response strobe and interrupt outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtime       <= 64'h0;
            mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            clint_msip  <= 1'b0;
            clint_mtip  <= 1'b0;
            clint_ready <= 1'b0;
            clint_rdata <= 32'h0;
        end else begin
            mtime       <= mtime_nxt;
            mtimecmp    <= mtimecmp_nxt;
            clint_msip  <= msip_nxt;
            clint_mtip  <= (mtime_nxt >= mtimecmp_nxt);
            clint_ready <= clint_valid;
            clint_rdata <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_clint.sv
// Directed testbench for clint: register map, RTC tick period, timer compare,
// carry/collision, byte strobes, unmapped offsets, back-to-back and reset.
`timescale 1ns/1ps
module tb_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        reset;
    logic        clock;
    logic        clint_valid;
    logic        clint_instr;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;

    int errors = 0;
    int checks = 0;

    clint dut (
        .reset       (reset),
        .clock       (clock),
        .clint_valid (clint_valid),
        .clint_instr (clint_instr),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One request; returns the response sampled one clock after acceptance.
    task automatic bus(input logic [31:0] off, input logic [31:0] wd, input logic [3:0] st,
                       input logic ins, output logic [31:0] rd, output logic rdy);
        clint_valid = 1'b1;
        clint_addr  = BASE + off;
        clint_wdata = wd;
        clint_wstrb = st;
        clint_instr = ins;
        @(posedge clock); #1;
        rd  = clint_rdata;
        rdy = clint_ready;
        clint_valid = 1'b0;
        clint_wstrb = 4'b0000;
        clint_instr = 1'b0;
    endtask

    // Waits for the next mtime change; n is the number of clocks waited.
    task automatic wait_tick(output int n);
        logic [63:0] prev;
        prev = clint_mtime;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (clint_mtime == prev && n < 4000);
        checks++;
        if (clint_mtime == prev) begin
            errors++;
            $display("FAIL tick_timeout: mtime stuck at %h after %0d clocks", clint_mtime, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clint_valid = 1'b0; clint_instr = 1'b0; clint_addr = '0;
        clint_wdata = '0;   clint_wstrb = '0;
        repeat (3) @(posedge clock); #1;
        checks++;
        if ({clint_ready, clint_msip, clint_mtip, clint_rdata, clint_mtime} !== 99'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b msip=%b mtip=%b rdata=%h mtime=%h expected all 0",
                     clint_ready, clint_msip, clint_mtip, clint_rdata, clint_mtime);
        end
        reset = 1'b1;
    endtask

    task automatic test_idle_reads();
        logic [31:0] rd; logic rdy;
        logic [31:0] offs [5];
        logic [31:0] exps [5];
        offs = '{32'h0, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC};
        exps = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            bus(offs[i], 32'h0, 4'b0000, 1'b0, rd, rdy);
            checks++;
            if (rdy !== 1'b1 || rd !== exps[i]) begin
                errors++;
                $display("FAIL idle_read[%h]: ready=%b rdata=%h expected ready=1 rdata=%h",
                         offs[i], rdy, rd, exps[i]);
            end
        end
        @(posedge clock); #1;
        checks++;
        if (clint_ready !== 1'b0 || clint_mtip !== 1'b0) begin
            errors++;
            $display("FAIL idle_after: ready=%b mtip=%b expected 0 0", clint_ready, clint_mtip);
        end
    endtask

    task automatic test_tick_period();
        int n;
        wait_tick(n);
        checks++;
        if (clint_mtime !== 64'd1) begin
            errors++;
            $display("FAIL first_tick: mtime=%h expected 1", clint_mtime);
        end
        for (int i = 2; i <= 10; i++) begin
            wait_tick(n);
            checks++;
            if (n != 1524) begin
                errors++;
                $display("FAIL tick_period[%0d]: %0d clocks expected 1524", i, n);
            end
        end
        checks++;
        if (clint_mtime !== 64'd10) begin
            errors++;
            $display("FAIL mtime_after_10: mtime=%h expected 10", clint_mtime);
        end
    endtask

    task automatic test_timer_irq();
        logic [31:0] rd; logic rdy; int n;
        logic exp_mtip;
        wait_tick(n);
        bus(32'hBFFC, 32'h0, 4'hF, 1'b0, rd, rdy);
        bus(32'hBFF8, 32'h0, 4'hF, 1'b0, rd, rdy);
        bus(32'h4004, 32'h0, 4'hF, 1'b0, rd, rdy);
        bus(32'h4000, 32'h5, 4'hF, 1'b0, rd, rdy);
        checks++;
        if (rdy !== 1'b1 || rd !== 32'h0 || clint_mtip !== 1'b0) begin
            errors++;
            $display("FAIL cmp_write: ready=%b rdata=%h mtip=%b expected 1 0 0", rdy, rd, clint_mtip);
        end
        for (int k = 1; k <= 5; k++) begin
            wait_tick(n);
            exp_mtip = (k >= 5);
            checks++;
            if (clint_mtime !== 64'(k) || clint_mtip !== exp_mtip) begin
                errors++;
                $display("FAIL timer_tick[%0d]: mtime=%h mtip=%b expected %h %b",
                         k, clint_mtime, clint_mtip, 64'(k), exp_mtip);
            end
        end
        bus(32'h4000, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, rdy);
        checks++;
        if (rdy !== 1'b1 || clint_mtip !== 1'b0) begin
            errors++;
            $display("FAIL cmp_raise: ready=%b mtip=%b expected 1 0", rdy, clint_mtip);
        end
        @(posedge clock); #1;
        checks++;
        if (clint_mtip !== 1'b0) begin
            errors++;
            $display("FAIL cmp_raise_hold: mtip=%b expected 0", clint_mtip);
        end
    endtask

    task automatic test_carry_collision();
        logic [31:0] rd; logic rdy; int n;
        wait_tick(n);
        bus(32'hBFFC, 32'h0, 4'hF, 1'b0, rd, rdy);
        bus(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, rdy);
        checks++;
        if (clint_mtime !== 64'h0000_0000_FFFF_FFFF) begin
            errors++;
            $display("FAIL mtime_write: mtime=%h expected 00000000ffffffff", clint_mtime);
        end
        wait_tick(n);
        checks++;
        if (clint_mtime !== 64'h0000_0001_0000_0000 || clint_mtip !== 1'b1) begin
            errors++;
            $display("FAIL carry: mtime=%h mtip=%b expected 0000000100000000 1", clint_mtime, clint_mtip);
        end
        bus(32'hBFFC, 32'h0, 4'h0, 1'b0, rd, rdy);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL carry_read_hi: rdata=%h expected 00000001", rd);
        end
        bus(32'hBFF8, 32'h0, 4'h0, 1'b0, rd, rdy);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL carry_read_lo: rdata=%h expected 00000000", rd);
        end
        // Land an mtime low write exactly on the next tick cycle.
        wait_tick(n);
        repeat (1523) begin
            @(posedge clock); #1;
        end
        bus(32'hBFF8, 32'h1234_5678, 4'hF, 1'b0, rd, rdy);
        checks++;
        if (clint_mtime !== 64'h0000_0001_1234_5678) begin
            errors++;
            $display("FAIL collision: mtime=%h expected 0000000112345678", clint_mtime);
        end
        bus(32'hBFF8, 32'h0, 4'h0, 1'b0, rd, rdy);
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL collision_read: rdata=%h expected 12345678", rd);
        end
        wait_tick(n);
        checks++;
        if (n != 1523 || clint_mtime !== 64'h0000_0001_1234_5679) begin
            errors++;
            $display("FAIL divider_undisturbed: %0d clocks mtime=%h expected 1523 0000000112345679",
                     n, clint_mtime);
        end
    endtask

    task automatic test_strobes_msip();
        logic [31:0] rd; logic rdy;
        bus(32'h4000, 32'h0, 4'b0011, 1'b0, rd, rdy);
        bus(32'h4000, 32'h0, 4'b0000, 1'b0, rd, rdy);
        checks++;
        if (rd !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL cmp_strobe: rdata=%h expected ffff0000", rd);
        end
        bus(32'h0, 32'hFFFF_FFFF, 4'b0010, 1'b0, rd, rdy);
        checks++;
        if (clint_msip !== 1'b0) begin
            errors++;
            $display("FAIL msip_wrong_lane: msip=%b expected 0", clint_msip);
        end
        bus(32'h0, 32'hFFFF_FFFF, 4'b0001, 1'b0, rd, rdy);
        checks++;
        if (rdy !== 1'b1 || clint_msip !== 1'b1) begin
            errors++;
            $display("FAIL msip_set: ready=%b msip=%b expected 1 1", rdy, clint_msip);
        end
        bus(32'h0, 32'h0, 4'b0000, 1'b0, rd, rdy);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL msip_read: rdata=%h expected 00000001", rd);
        end
        bus(32'h0, 32'h0, 4'hF, 1'b0, rd, rdy);
        checks++;
        if (clint_msip !== 1'b0) begin
            errors++;
            $display("FAIL msip_clear: msip=%b expected 0", clint_msip);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; logic rdy;
        bus(32'h0008, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, rdy);
        checks++;
        if (rdy !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_write: ready=%b rdata=%h expected 1 0", rdy, rd);
        end
        bus(32'h0008, 32'h0, 4'h0, 1'b0, rd, rdy);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: rdata=%h expected 0", rd);
        end
        bus(32'h0, 32'h0, 4'h0, 1'b0, rd, rdy);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_msip: rdata=%h expected 0", rd);
        end
        bus(32'h4000, 32'h0, 4'h0, 1'b0, rd, rdy);
        checks++;
        if (rd !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL unmapped_cmp: rdata=%h expected ffff0000", rd);
        end
        bus(32'hBFFC, 32'h0, 4'h0, 1'b0, rd, rdy);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL unmapped_mtime_hi: rdata=%h expected 00000001", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic rdy;
        clint_valid = 1'b1; clint_addr = BASE; clint_wdata = 32'h1; clint_wstrb = 4'b0001;
        @(posedge clock); #1;
        checks++;
        if (clint_ready !== 1'b1 || clint_rdata !== 32'h0 || clint_msip !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write: ready=%b rdata=%h msip=%b expected 1 0 1",
                     clint_ready, clint_rdata, clint_msip);
        end
        clint_wstrb = 4'b0000;
        @(posedge clock); #1;
        checks++;
        if (clint_ready !== 1'b1 || clint_rdata !== 32'h1) begin
            errors++;
            $display("FAIL b2b_read_msip: ready=%b rdata=%h expected 1 00000001", clint_ready, clint_rdata);
        end
        clint_addr = BASE + 32'h4000;
        @(posedge clock); #1;
        checks++;
        if (clint_ready !== 1'b1 || clint_rdata !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL b2b_read_cmp: ready=%b rdata=%h expected 1 ffff0000", clint_ready, clint_rdata);
        end
        clint_valid = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (clint_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: ready=%b expected 0", clint_ready);
        end
        bus(32'h0, 32'h0, 4'hF, 1'b1, rd, rdy);
        checks++;
        if (rdy !== 1'b1 || rd !== 32'h1 || clint_msip !== 1'b1) begin
            errors++;
            $display("FAIL fetch_is_read: ready=%b rdata=%h msip=%b expected 1 00000001 1", rdy, rd, clint_msip);
        end
    endtask

    task automatic test_reset_mid_request();
        logic [31:0] rd; logic rdy;
        checks++;
        if (clint_mtip !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_mtip: mtip=%b expected 1", clint_mtip);
        end
        clint_valid = 1'b1; clint_addr = BASE + 32'h4000; clint_wdata = 32'h0; clint_wstrb = 4'hF;
        #2 reset = 1'b0;
        @(posedge clock); #1;
        clint_valid = 1'b0; clint_wstrb = 4'h0;
        checks++;
        if ({clint_ready, clint_msip, clint_mtip, clint_rdata, clint_mtime} !== 99'h0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b msip=%b mtip=%b rdata=%h mtime=%h expected all 0",
                     clint_ready, clint_msip, clint_mtip, clint_rdata, clint_mtime);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        bus(32'h4000, 32'h0, 4'h0, 1'b0, rd, rdy);
        checks++;
        if (rdy !== 1'b1 || rd !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_cmp: ready=%b rdata=%h expected 1 ffffffff", rdy, rd);
        end
    endtask

    initial begin
        test_reset();
        test_idle_reads();
        test_tick_period();
        test_timer_irq();
        test_carry_collision();
        test_strobes_msip();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
